// File: rtl/stack_seq_pkg.sv
// Shared opcodes, FSM state encoding and default sizes for the stack op sequencer.
// Consumers: stack_seq_alu (STACK_SEQ_SATURATE_EN aware) and stack_op_sequencer.
package stack_seq_pkg;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_DEPTH = 8;
    localparam int DEFAULT_CW    = 4;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_PUSH = 3'd1;
    localparam logic [2:0] OP_POP  = 3'd2;
    localparam logic [2:0] OP_ADD  = 3'd3;
    localparam logic [2:0] OP_SUB  = 3'd4;
    localparam logic [2:0] OP_AND  = 3'd5;
    localparam logic [2:0] OP_DUP  = 3'd6;
    localparam logic [2:0] OP_RSVD = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_TOS_A = 3'd1,
        ST_CAP_A = 3'd2,
        ST_TOS_B = 3'd3,
        ST_CAP_B = 3'd4,
        ST_WRITE = 3'd5
    } state_t;

endpackage

// File: rtl/stack_seq_alu.sv
// Combinational binary operator r = b op a, where a is the former top of stack.
// STACK_SEQ_SATURATE_EN: ADD clamps to all-ones, SUB clamps to zero; otherwise wrap-around.
module stack_seq_alu
    import stack_seq_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic [2:0]    op_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] r_o
);

`ifdef STACK_SEQ_SATURATE_EN
    localparam bit SATURATE = 1'b1;
`else
    localparam bit SATURATE = 1'b0;
`endif

    logic [DW:0] sum;
    logic [DW:0] diff;

    always_comb begin
        sum  = {1'b0, b_i} + {1'b0, a_i};
        diff = {1'b0, b_i} - {1'b0, a_i};
        r_o  = '0;
        case (op_i)
            // The extra top bit is carry for ADD and borrow for SUB.
            OP_ADD:  r_o = (SATURATE && sum[DW])  ? '1 : sum[DW-1:0];
            OP_SUB:  r_o = (SATURATE && diff[DW]) ? '0 : diff[DW-1:0];
            OP_AND:  r_o = b_i & a_i;
            default: r_o = '0;
        endcase
    end

endmodule

// File: rtl/stack_op_sequencer.sv
// Stack-machine instruction sequencer issuing push/pop/tos strobes to an external Stack.
// STACK_SEQ_SATURATE_EN selects clamping ADD/SUB inside stack_seq_alu.
module stack_op_sequencer
    import stack_seq_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DW    = DEFAULT_DW,
    parameter int CW    = DEFAULT_CW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          instr_valid,
    output logic          instr_ready,
    input  logic [2:0]    instr_op,
    input  logic [DW-1:0] instr_imm,
    output logic          push_sig,
    output logic          pop_sig,
    output logic          tos_sig,
    output logic [DW-1:0] push_data,
    input  logic [DW-1:0] out_data,
    output logic          result_valid,
    output logic [DW-1:0] result_data,
    output logic          err,
    output logic [CW-1:0] depth
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] TWO_C   = CW'(2);

    state_t        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [DW-1:0] a_q, a_d;
    logic [DW-1:0] push_data_q, push_data_d;
    logic [DW-1:0] result_q, result_d;
    logic [DW-1:0] alu_r;
    logic [CW-1:0] depth_q, depth_d;
    logic          push_q, push_d;
    logic          pop_q, pop_d;
    logic          tos_q, tos_d;
    logic          err_q, err_d;
    logic          accept;
    logic          reject;

    // Operand b is the Stack's top during CAP_B, i.e. the second entry (B).
    stack_seq_alu #(.DW(DW)) u_alu (
        .op_i (op_q),
        .a_i  (a_q),
        .b_i  (out_data),
        .r_o  (alu_r)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        push_data_d = push_data_q;
        result_d    = result_q;
        err_d       = 1'b0;
        accept      = instr_valid && (state_q == ST_IDLE);
        reject      = 1'b0;

        case (instr_op)
            OP_PUSH:                reject = (depth_q == DEPTH_C);
            OP_POP:                 reject = (depth_q == '0);
            OP_ADD, OP_SUB, OP_AND: reject = (depth_q < TWO_C);
            OP_DUP:                 reject = (depth_q == '0) || (depth_q == DEPTH_C);
            OP_RSVD:                reject = 1'b1;
            default:                reject = 1'b0;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (accept && reject) begin
                    err_d = 1'b1;
                end else if (accept) begin
                    op_d = instr_op;
                    case (instr_op)
                        OP_PUSH: begin
                            state_d     = ST_WRITE;
                            push_data_d = instr_imm;
                        end
                        OP_POP, OP_ADD, OP_SUB, OP_AND, OP_DUP: state_d = ST_TOS_A;
                        default:                                state_d = ST_IDLE;
                    endcase
                end
            end
            ST_TOS_A: state_d = ST_CAP_A;
            ST_CAP_A: begin
                a_d = out_data;
                if (op_q == OP_POP) begin
                    result_d = out_data;
                    state_d  = ST_IDLE;
                end else if (op_q == OP_DUP) begin
                    push_data_d = out_data;
                    state_d     = ST_WRITE;
                end else begin
                    state_d = ST_TOS_B;
                end
            end
            ST_TOS_B: state_d = ST_CAP_B;
            ST_CAP_B: begin
                push_data_d = alu_r;
                state_d     = ST_WRITE;
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Strobes are registered from the state being entered; depth moves with them.
        tos_d  = (state_d == ST_TOS_A) || (state_d == ST_TOS_B);
        pop_d  = (state_d == ST_CAP_B) || ((state_d == ST_CAP_A) && (op_q != OP_DUP));
        push_d = (state_d == ST_WRITE);

        depth_d = depth_q;
        if (push_d) begin
            depth_d = depth_q + ONE_C;
        end else if (pop_d) begin
            depth_d = depth_q - ONE_C;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            depth_q  <= '0;
            result_q <= '0;
            push_q   <= 1'b0;
            pop_q    <= 1'b0;
            tos_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            depth_q  <= depth_d;
            result_q <= result_d;
            push_q   <= push_d;
            pop_q    <= pop_d;
            tos_q    <= tos_d;
            err_q    <= err_d;
        end
    end

    // NOTE: operand and push-data registers are not reset; each is written before it is ever used.
    always_ff @(posedge clk) begin
        a_q         <= a_d;
        push_data_q <= push_data_d;
    end

    // The popped value is presented straight from the Stack during CAP_A, then held.
    assign result_valid = (state_q == ST_CAP_A) && (op_q == OP_POP);
    assign result_data  = result_valid ? out_data : result_q;

    assign instr_ready = (state_q == ST_IDLE);
    assign push_sig    = push_q;
    assign pop_sig     = pop_q;
    assign tos_sig     = tos_q;
    assign push_data   = push_data_q;
    assign err         = err_q;
    assign depth       = depth_q;

endmodule

// File: tb/tb_stack_op_sequencer.sv
// Self-checking bench for stack_op_sequencer: Stack emulation, instruction-level reference model,
// per-cycle compare process, directed cases and randomized instruction stream.
module tb_stack_op_sequencer;
    import stack_seq_pkg::*;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int CW    = 4;

`ifdef STACK_SEQ_SATURATE_EN
    localparam logic [7:0] ADD_LIT = 8'hFF;
`else
    localparam logic [7:0] ADD_LIT = 8'h10;
`endif

    logic          clk;
    logic          rst_n;
    logic          instr_valid;
    logic          instr_ready;
    logic [2:0]    instr_op;
    logic [DW-1:0] instr_imm;
    logic          push_sig;
    logic          pop_sig;
    logic          tos_sig;
    logic [DW-1:0] push_data;
    logic [DW-1:0] out_data;
    logic          result_valid;
    logic [DW-1:0] result_data;
    logic          err;
    logic [CW-1:0] depth;

    stack_op_sequencer #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_op     (instr_op),
        .instr_imm    (instr_imm),
        .push_sig     (push_sig),
        .pop_sig      (pop_sig),
        .tos_sig      (tos_sig),
        .push_data    (push_data),
        .out_data     (out_data),
        .result_valid (result_valid),
        .result_data  (result_data),
        .err          (err),
        .depth        (depth)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Stack emulation: reacts to the strobes, presents top the cycle after tos_sig, noise otherwise.
    logic [7:0] env_mem [0:DEPTH-1];
    int         env_sp;

    always @(posedge clk) begin
        if (!rst_n) begin
            env_sp   <= 0;
            out_data <= '0;
        end else begin
            out_data <= 8'($urandom);
            if (push_sig && env_sp < DEPTH) begin
                env_mem[env_sp] <= push_data;
                env_sp          <= env_sp + 1;
            end else if (pop_sig && env_sp > 0) begin
                env_sp <= env_sp - 1;
            end
            if (tos_sig && env_sp > 0) out_data <= env_mem[env_sp-1];
        end
    end

    function automatic logic [7:0] env_top();
        if (env_sp > 0) return env_mem[env_sp-1];
        return 8'h00;
    endfunction

    // Reference model: stack contents as a queue, expected per-cycle outputs as records.
    typedef struct {
        logic       push, pop, tos, err, rv, rdy;
        logic [3:0] dep;
        logic [7:0] pdata, rdata;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] mstk[$];
    logic [7:0] m_result = '0;
    bit         chk_en   = 1'b0;
    bit         cur_rdy  = 1'b1;

    function automatic logic [7:0] alu_model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int s;
        case (op)
            OP_ADD: begin
                s = int'(b) + int'(a);
`ifdef STACK_SEQ_SATURATE_EN
                if (s > 255) s = 255;
`endif
            end
            OP_SUB: begin
                s = int'(b) - int'(a);
`ifdef STACK_SEQ_SATURATE_EN
                if (s < 0) s = 0;
`endif
            end
            default: s = int'(a & b);
        endcase
        return 8'(s);
    endfunction

    task automatic push_rec(input bit p, input bit po, input bit t, input bit er, input bit rv,
                            input bit rdy, input int dep, input logic [7:0] pd);
        exp_t e;
        e.push = p; e.pop = po; e.tos = t; e.err = er; e.rv = rv; e.rdy = rdy;
        e.dep = 4'(dep); e.pdata = pd; e.rdata = m_result;
        exp_q.push_back(e);
    endtask

    task automatic model_issue(input logic [2:0] op, input logic [7:0] imm);
        int         d;
        bit         rej;
        logic [7:0] a, b, r;
        d   = mstk.size();
        rej = (op == OP_RSVD) || ((op == OP_PUSH || op == OP_DUP) && d == DEPTH) ||
              ((op == OP_POP || op == OP_DUP) && d == 0) ||
              ((op == OP_ADD || op == OP_SUB || op == OP_AND) && d < 2);
        if (rej) begin
            push_rec(0, 0, 0, 1, 0, 1, d, 8'h00);
            return;
        end
        case (op)
            OP_PUSH: begin
                mstk.push_back(imm);
                push_rec(1, 0, 0, 0, 0, 0, d + 1, imm);
            end
            OP_POP: begin
                a = mstk.pop_back();
                push_rec(0, 0, 1, 0, 0, 0, d, 8'h00);
                m_result = a;
                push_rec(0, 1, 0, 0, 1, 0, d - 1, 8'h00);
            end
            OP_ADD, OP_SUB, OP_AND: begin
                a = mstk.pop_back();
                b = mstk.pop_back();
                r = alu_model(op, a, b);
                push_rec(0, 0, 1, 0, 0, 0, d, 8'h00);
                push_rec(0, 1, 0, 0, 0, 0, d - 1, 8'h00);
                push_rec(0, 0, 1, 0, 0, 0, d - 1, 8'h00);
                push_rec(0, 1, 0, 0, 0, 0, d - 2, 8'h00);
                push_rec(1, 0, 0, 0, 0, 0, d - 1, r);
                mstk.push_back(r);
            end
            OP_DUP: begin
                a = mstk[$];
                push_rec(0, 0, 1, 0, 0, 0, d, 8'h00);
                push_rec(0, 0, 0, 0, 0, 0, d, 8'h00);
                push_rec(1, 0, 0, 0, 0, 0, d + 1, a);
                mstk.push_back(a);
            end
            default: ;
        endcase
    endtask

    // Single compare process: one expected record per cycle, idle expectation when none pending.
    always @(posedge clk) begin : cmp
        exp_t e;
        #1;
        if (chk_en) begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e.push = 0; e.pop = 0; e.tos = 0; e.err = 0; e.rv = 0; e.rdy = 1;
                e.dep = 4'(mstk.size()); e.pdata = 8'h00; e.rdata = m_result;
            end
            cur_rdy = e.rdy;
            check("push_sig", push_sig, e.push);
            check("pop_sig", pop_sig, e.pop);
            check("tos_sig", tos_sig, e.tos);
            check("err", err, e.err);
            check("result_valid", result_valid, e.rv);
            check("instr_ready", instr_ready, e.rdy);
            check("depth", depth, e.dep);
            check("result_data", result_data, e.rdata);
            if (e.push) check("push_data", push_data, e.pdata);
        end
    end

    // Called at a negedge; drives junk while the model says busy, then offers the instruction.
    task automatic step_instr(input logic [2:0] op, input logic [7:0] imm);
        while (!cur_rdy) begin
            instr_valid = 1'($urandom_range(0, 1));
            instr_op    = 3'($urandom);
            instr_imm   = 8'($urandom);
            @(negedge clk);
        end
        instr_valid = 1'b1;
        instr_op    = op;
        instr_imm   = imm;
        model_issue(op, imm);
        @(negedge clk);
        instr_valid = 1'b0;
    endtask

    task automatic drain();
        while (exp_q.size() > 0 || !cur_rdy) @(negedge clk);
    endtask

    task automatic do_reset();
        chk_en      = 1'b0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        exp_q.delete();
        mstk.delete();
        m_result = '0;
        @(posedge clk); #1;
        check("rst_push", push_sig, 0);
        check("rst_pop", pop_sig, 0);
        check("rst_tos", tos_sig, 0);
        check("rst_err", err, 0);
        check("rst_rvalid", result_valid, 0);
        check("rst_depth", depth, 0);
        check("rst_rdata", result_data, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rel_ready", instr_ready, 1);
        check("rel_depth", depth, 0);
        check("rel_strobes", {push_sig, pop_sig, tos_sig}, 0);
        @(negedge clk);
        cur_rdy = 1'b1;
        chk_en  = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] op;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr_op    = OP_NOP;
        instr_imm   = '0;
        @(negedge clk);
        do_reset();

        // 5 - 3 = 2, depth 1,2,1,0,1
        step_instr(OP_PUSH, 8'h05);
        step_instr(OP_PUSH, 8'h03);
        step_instr(OP_SUB, 8'h00);
        drain();
        check("sub_model", mstk[$], 8'h02);
        check("sub_env_top", env_top(), 8'h02);
        step_instr(OP_POP, 8'h00);

        step_instr(OP_PUSH, 8'h7A);
        step_instr(OP_POP, 8'h00);
        drain();
        check("pop_result", result_data, 8'h7A);
        check("pop_depth", depth, 0);

        step_instr(OP_POP, 8'h00);
        step_instr(OP_PUSH, 8'h44);
        step_instr(OP_ADD, 8'h00);
        step_instr(OP_NOP, 8'h00);
        step_instr(OP_DUP, 8'h00);
        step_instr(OP_AND, 8'h00);
        step_instr(OP_POP, 8'h00);
        drain();
        check("and_result", result_data, 8'h44);
        step_instr(OP_RSVD, 8'h00);

        for (int i = 0; i < DEPTH; i++) step_instr(OP_PUSH, 8'(i * 17));
        step_instr(OP_PUSH, 8'h11);
        step_instr(OP_DUP, 8'h00);
        drain();
        check("full_depth", depth, 8);
        check("full_env_top", env_top(), 8'h77);
        for (int i = 0; i < DEPTH; i++) step_instr(OP_POP, 8'h00);

        step_instr(OP_PUSH, 8'hF0);
        step_instr(OP_PUSH, 8'h20);
        step_instr(OP_ADD, 8'h00);
        drain();
        check("add_model", mstk[$], ADD_LIT);
        check("add_env_top", env_top(), ADD_LIT);
        step_instr(OP_POP, 8'h00);

        // Abort an ADD with reset while TOS_B is active.
        step_instr(OP_PUSH, 8'h01);
        step_instr(OP_PUSH, 8'h02);
        step_instr(OP_ADD, 8'h00);
        @(negedge clk);
        @(negedge clk);
        do_reset();

        repeat (400) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            op = 3'($urandom_range(0, 7));
            if (mstk.size() < 2 && $urandom_range(0, 1) == 1) op = OP_PUSH;
            step_instr(op, 8'($urandom));
        end
        drain();
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
